alarm_snooze_ctrl: RTL
======================

ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

Interface
REQ-001 Parameter RING_SECS, default 60: maximum seconds of continuous buzzing before auto-off.
REQ-002 Parameter SNOOZE_SECS, default 300: snooze duration in seconds.
REQ-003 Parameter MAX_SNOOZE, default 3: maximum snoozes per alarm event.
REQ-004 clk  input  1  -- single clock, the 1 Hz seconds Pulse; one cycle = one second.
REQ-005 rst  input  1  -- synchronous reset, active-high.
REQ-006 tsec, tmin, thrs  input  7 each  -- current time, binary (0-59, 0-59, 0-23).
REQ-007 amin, ahrs  input  7 each  -- alarm setting, binary.
REQ-008 tday  input  7  -- day of week, 0-6, from the mod-7 day counter.
REQ-009 alarmon  input  1  -- alarm enable switch, level.
REQ-010 snooze  input  1  -- snooze button, level; internally edge-detected.
REQ-011 buzz  output  1  -- alarm sounding.
REQ-012 state  output  2  -- FSM state (IDLE=0, RING=1, SNOOZE=2), for debug/display.
REQ-013 snooze_used  output  2  -- snoozes consumed in the current event.

Function
REQ-014 match SHALL be tsec==0 && tmin==amin && thrs==ahrs && day_ok; day_ok is defined in Configuration.
REQ-015 snz_edge SHALL be snooze && !snooze_q, where snooze_q is snooze registered once per clk.
REQ-016 buzz SHALL equal (state==RING), decoded from registered state with no combinational path from inputs.
REQ-017 Priority every cycle, in every state: !alarmon forces next state IDLE, clears ring_ct, snz_ct and snooze_used.
REQ-018 IDLE: match && alarmon -> RING with ring_ct=0; snz_edge is ignored; buzz rises on the clk edge that samples tsec==0.
REQ-019 RING: snz_edge && snooze_used<MAX_SNOOZE -> SNOOZE, snz_ct=0, snooze_used+1.
REQ-020 RING: snz_edge with snooze_used==MAX_SNOOZE is ignored; ringing continues.
REQ-021 RING: otherwise, if ring_ct==RING_SECS-1 -> IDLE and clear snooze_used; else ring_ct+1.
REQ-022 RING: an accepted snz_edge in the same cycle as the timeout SHALL win, and the next state is SNOOZE.
REQ-023 SNOOZE: snz_ct==SNOOZE_SECS-1 -> RING with ring_ct=0; else snz_ct+1; snz_edge is ignored.
REQ-024 match while in RING or SNOOZE SHALL be ignored and SHALL NOT restart counters.
REQ-025 Width: ring_ct and snz_ct are $clog2 of their parameter; counters never wrap past their terminal values.
REQ-026 Encoding 3 is illegal and SHALL recover to IDLE on the next clk.
REQ-027 Alarm time changed mid-event SHALL NOT affect the current event.

Reset
REQ-028 rst SHALL have priority over all other inputs.
REQ-029 On rst: state=IDLE, buzz=0, snooze_used=0, ring_ct=0, snz_ct=0, snooze_q=0.
REQ-030 rst asserted in RING or SNOOZE SHALL abort the event, and buzz=0 on the next clk.
REQ-031 snooze held high across reset deasserts produces one edge; it is ignored because the state is IDLE.

Configuration
REQ-032 Macro WEEKEND_SKIP_EN: when defined, day_ok = (tday<5), so there is no alarm on days 5 and 6.
REQ-033 Without WEEKEND_SKIP_EN, day_ok = 1, so the alarm fires on all days.
REQ-034 The macro SHALL NOT alter ports or any other behaviour.

Verification
REQ-035 Scenario: amin=30, ahrs=7, alarmon=1, time runs 07:29:59 -> 07:30:00 -> buzz=1 after the 07:30:00 edge; buzz=0 after 60 cycles; state=IDLE.
REQ-036 Scenario: while ringing, pulse snooze once -> buzz=0, snooze_used=1; buzz=1 again exactly 300 cycles later.
REQ-037 Scenario: snooze 3 times, then a 4th press while ringing -> ringing continues, snooze_used=3, auto-off at RING_SECS.
REQ-038 Scenario: drop alarmon while in SNOOZE -> state=IDLE next cycle; no re-ring at snooze expiry; snooze_used=0.
REQ-039 Scenario: tday=5, match, WEEKEND_SKIP_EN defined -> buzz stays 0; same stimulus without the macro -> buzz=1.
REQ-040 Scenario: rst pulse during RING with snooze held high -> buzz=0, all outputs at reset values, no SNOOZE entry.

Source files
------------

// File: rtl/alarm_snooze_ctrl.sv
// alarm_snooze_ctrl: alarm FSM with timed ringing, a limited snooze count and an optional weekend skip (WEEKEND_SKIP_EN)
module alarm_snooze_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] tsec,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  input  logic [6:0] tday,
  input  logic       alarmon,
  input  logic       snooze,
  output logic       buzz,
  output logic [1:0] state,
  output logic [1:0] snooze_used
);
  localparam int RW = RING_SECS > 1 ? $clog2(RING_SECS) : 1;
  localparam int SW = SNOOZE_SECS > 1 ? $clog2(SNOOZE_SECS) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_SECS - 1);
  localparam logic [1:0] MAX_U = 2'(MAX_SNOOZE);
  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2, BAD = 2'd3} st_t;
  st_t st, st_n;
  logic [RW-1:0] ring_ct, ring_ct_n;
  logic [SW-1:0] snz_ct, snz_ct_n;
  logic [1:0] used_n;
  logic snooze_q, day_ok, match, snz_edge;
`ifdef WEEKEND_SKIP_EN
  assign day_ok = tday < 7'd5;
`else
  logic unused_tday;
  assign unused_tday = ^tday;
  assign day_ok = 1'b1;
`endif
  assign match = tsec == 7'd0 && tmin == amin && thrs == ahrs && day_ok;
  assign snz_edge = snooze && !snooze_q;
  assign buzz = st == RING;
  assign state = st;
  always_comb begin
    st_n = st;
    ring_ct_n = ring_ct;
    snz_ct_n = snz_ct;
    used_n = snooze_used;
    if (!alarmon || st == BAD) begin
      st_n = IDLE;
      ring_ct_n = '0;
      snz_ct_n = '0;
      used_n = '0;
    end else case (st)
      IDLE: if (match) begin
        st_n = RING;
        ring_ct_n = '0;
      end
      RING: if (snz_edge && snooze_used < MAX_U) begin
        st_n = SNOOZE;
        snz_ct_n = '0;
        used_n = snooze_used + 2'd1;
      end else if (ring_ct == RING_LAST) begin
        st_n = IDLE;
        ring_ct_n = '0;
        used_n = '0;
      end else ring_ct_n = ring_ct + RW'(1);
      default: if (snz_ct == SNZ_LAST) begin
        st_n = RING;
        ring_ct_n = '0;
      end else snz_ct_n = snz_ct + SW'(1);
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ring_ct <= '0;
      snz_ct <= '0;
      snooze_used <= '0;
      snooze_q <= 1'b0;
    end else begin
      st <= st_n;
      ring_ct <= ring_ct_n;
      snz_ct <= snz_ct_n;
      snooze_used <= used_n;
      snooze_q <= snooze;
    end
  end
endmodule
